// File: rtl/cart_mbc1.sv
// MBC1 cartridge mapper: latches the console address, decodes bank-control
// writes on the rising edge of cs and maps ROM and cart-RAM addresses.
module cart_mbc1 #(
  parameter logic [6:0] ROM_MASK = 7'h7F,
  parameter logic [1:0] RAM_MASK = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        cale,
  input  logic        cs,
  input  logic        wr,
  output logic [20:0] rom_a,
  output logic        rom_rd,
  input  logic [7:0]  rom_q,
  output logic [14:0] ram_a,
  output logic        ram_rd,
  output logic        ram_we,
  output logic [7:0]  ram_d,
  input  logic [7:0]  ram_q
);

  logic [15:0] alat_q, alat_d;
  logic        cs_q, cs_d;
  logic        ram_en_q, ram_en_d;
  logic [4:0]  bank1_q, bank1_d;
  logic [1:0]  bank2_q, bank2_d;
  logic        mode_q, mode_d;

  logic       rom0, romx, cram, access, wr_acc;
  logic [1:0] hi_bank;

  // Decode always uses the registered latch, so a coinciding cale sees the old address.
  assign rom0    = (alat_q[15:14] == 2'b00);
  assign romx    = (alat_q[15:14] == 2'b01);
  assign cram    = (alat_q[15:13] == 3'b101);
  assign access  = cs & ~cs_q;
  assign wr_acc  = access & wr;
  assign hi_bank = mode_q ? bank2_q : 2'b00;

  always_comb begin
    alat_d   = cale ? a : alat_q;
    cs_d     = cs;
    ram_en_d = ram_en_q;
    bank1_d  = bank1_q;
    bank2_d  = bank2_q;
    mode_d   = mode_q;
    if (wr_acc) begin
      case (alat_q[15:13])
        3'b000: ram_en_d = (din[3:0] == 4'hA);
        3'b001: bank1_d  = (din[4:0] == 5'd0) ? 5'd1 : din[4:0];
        3'b010: bank2_d  = din[1:0];
        3'b011: mode_d   = din[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alat_q   <= 16'h0000;
      cs_q     <= 1'b0;
      ram_en_q <= 1'b0;
      bank1_q  <= 5'd1;
      bank2_q  <= 2'd0;
      mode_q   <= 1'b0;
    end else begin
      alat_q   <= alat_d;
      cs_q     <= cs_d;
      ram_en_q <= ram_en_d;
      bank1_q  <= bank1_d;
      bank2_q  <= bank2_d;
      mode_q   <= mode_d;
    end
  end

  always_comb begin
    if (rom0) rom_a = {hi_bank & ROM_MASK[6:5], 5'b0, alat_q[13:0]};
    else      rom_a = {{bank2_q, bank1_q} & ROM_MASK, alat_q[13:0]};
  end

  assign ram_a  = {hi_bank & RAM_MASK, alat_q[12:0]};
  assign ram_d  = din;
  assign rom_rd = ~rst & cs & ~wr & (rom0 | romx);
  assign ram_rd = ~rst & cs & ~wr & cram & ram_en_q;
  assign ram_we = ~rst & wr_acc & cram & ram_en_q;

  always_comb begin
    dout = 8'hFF;
    if (!rst && cs) begin
      if (rom0 || romx)         dout = rom_q;
      else if (cram && ram_en_q) dout = ram_q;
    end
  end

endmodule

// File: tb/tb_cart_mbc1.sv
// Randomized self-checking bench for cart_mbc1 against a bank-arithmetic model.
module tb_cart_mbc1;
  logic        clk, rst, cale, cs, wr;
  logic [15:0] a;
  logic [7:0]  din, dout, dout2, rom_q, ram_q, ram_d, ram_d2;
  logic [20:0] rom_a, rom_a2;
  logic [14:0] ram_a, ram_a2;
  logic        rom_rd, ram_rd, ram_we, rom_rd2, ram_rd2, ram_we2;

  int checks = 0, failures = 0;

  // model state
  bit       m_en, m_mode;
  int       m_b1, m_b2;

  // observations from the cs cycle of the last access
  logic [7:0]  o_dout, o_ram_d, c_rom_q, c_ram_q;
  logic [20:0] o_rom_a, o_rom_a2;
  logic [14:0] o_ram_a;
  logic        o_rom_rd, o_ram_rd, o_ram_we;

  cart_mbc1 dut (.clk(clk), .rst(rst), .a(a), .din(din), .dout(dout), .cale(cale),
    .cs(cs), .wr(wr), .rom_a(rom_a), .rom_rd(rom_rd), .rom_q(rom_q), .ram_a(ram_a),
    .ram_rd(ram_rd), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q));

  cart_mbc1 #(.ROM_MASK(7'h1F)) dut2 (.clk(clk), .rst(rst), .a(a), .din(din), .dout(dout2),
    .cale(cale), .cs(cs), .wr(wr), .rom_a(rom_a2), .rom_rd(rom_rd2), .rom_q(rom_q),
    .ram_a(ram_a2), .ram_rd(ram_rd2), .ram_we(ram_we2), .ram_d(ram_d2), .ram_q(ram_q));

  initial begin clk = 0; forever #5 clk = ~clk; end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int region(input logic [15:0] ad); // 0 rom0 1 romx 2 cram 3 none
    if (ad < 16'h4000) return 0;
    if (ad < 16'h8000) return 1;
    if (ad >= 16'hA000 && ad < 16'hC000) return 2;
    return 3;
  endfunction

  function automatic logic [20:0] exp_rom_a(input logic [15:0] ad, input int mask);
    int bank;
    if (ad < 16'h4000) bank = m_mode ? m_b2 * 32 : 0;
    else bank = m_b2 * 32 + m_b1;
    bank = bank & mask;
    return 21'(bank * 16384 + ad % 16384);
  endfunction

  function automatic logic [14:0] exp_ram_a(input logic [15:0] ad);
    int bank;
    bank = m_mode ? m_b2 : 0;
    return 15'(bank * 8192 + ad % 8192);
  endfunction

  function automatic void model_reset();
    m_en = 0; m_mode = 0; m_b1 = 1; m_b2 = 0;
  endfunction

  function automatic void model_write(input logic [15:0] ad, input logic [7:0] d);
    if (ad < 16'h2000)      m_en = (d % 16 == 10);
    else if (ad < 16'h4000) m_b1 = (d % 32 == 0) ? 1 : d % 32;
    else if (ad < 16'h6000) m_b2 = d % 4;
    else if (ad < 16'h8000) m_mode = d[0];
  endfunction

  task automatic capture();
    o_dout = dout; o_rom_a = rom_a; o_rom_a2 = rom_a2; o_ram_a = ram_a; o_ram_d = ram_d;
    o_rom_rd = rom_rd; o_ram_rd = ram_rd; o_ram_we = ram_we;
    c_rom_q = rom_q; c_ram_q = ram_q;
  endtask

  // cale cycle, then one cs cycle; outputs captured mid cs cycle
  task automatic bus(input logic [15:0] ad, input logic w, input logic [7:0] d);
    @(negedge clk); a = ad; cale = 1; cs = 0; wr = 0;
    @(negedge clk); cale = 0; cs = 1; wr = w; din = d;
    rom_q = 8'($urandom); ram_q = 8'($urandom);
    #1 capture();
    @(negedge clk); cs = 0; wr = 0;
  endtask

  task automatic wr_model(input logic [15:0] ad, input logic [7:0] d);
    bus(ad, 1, d); model_write(ad, d);
  endtask

  task automatic test_reset();
    rst = 1; cale = 0; cs = 1; wr = 0; a = 16'h4123; din = 0; rom_q = 8'h3C; ram_q = 8'hC3;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (rom_rd !== 0 || ram_rd !== 0 || ram_we !== 0) begin failures++;
      $display("FAIL reset_strobes got rom_rd=%b ram_rd=%b ram_we=%b exp 0", rom_rd, ram_rd, ram_we); end
    checks++; if (dout !== 8'hFF) begin failures++; $display("FAIL reset_dout got=%h exp=ff", dout); end
    checks++; if (rom_a !== 21'h0) begin failures++; $display("FAIL reset_rom_a got=%h exp=0", rom_a); end
    @(negedge clk); rst = 0; cs = 0;
    model_reset();
    bus(16'h4123, 0, 0);
    checks++; if (o_rom_a !== 21'h04123 || o_rom_rd !== 1) begin failures++;
      $display("FAIL first_read got rom_a=%h rom_rd=%b exp 04123/1", o_rom_a, o_rom_rd); end
    checks++; if (o_dout !== c_rom_q) begin failures++; $display("FAIL first_read_dout got=%h exp=%h", o_dout, c_rom_q); end
  endtask

  task automatic test_bank1();
    wr_model(16'h2100, 8'h00);
    bus(16'h4000, 0, 0);
    checks++; if (o_rom_a !== 21'h04000) begin failures++; $display("FAIL bank1_zero got=%h exp=04000", o_rom_a); end
    wr_model(16'h2100, 8'h1F);
    bus(16'h7FFF, 0, 0);
    checks++; if (o_rom_a !== 21'h07FFFF) begin failures++; $display("FAIL bank1_1f got=%h exp=07ffff", o_rom_a); end
  endtask

  task automatic test_mode();
    wr_model(16'h4000, 8'h03);
    wr_model(16'h6000, 8'h01);
    bus(16'h0000, 0, 0);
    checks++; if (o_rom_a !== 21'h180000) begin failures++; $display("FAIL mode_rom0 got=%h exp=180000", o_rom_a); end
    checks++; if (o_rom_a2 !== 21'h000000) begin failures++; $display("FAIL mode_rom0_mask1f got=%h exp=000000", o_rom_a2); end
  endtask

  task automatic test_ram();
    wr_model(16'h0000, 8'h00);
    bus(16'hA000, 0, 0);
    checks++; if (o_dout !== 8'hFF || o_ram_rd !== 0) begin failures++;
      $display("FAIL ram_disabled got dout=%h ram_rd=%b exp ff/0", o_dout, o_ram_rd); end
    wr_model(16'h6000, 8'h00);
    wr_model(16'h0000, 8'h0A);
    bus(16'hA123, 1, 8'h5A);
    checks++; if (o_ram_we !== 1 || o_ram_a !== 15'h0123 || o_ram_d !== 8'h5A) begin failures++;
      $display("FAIL ram_write got we=%b a=%h d=%h exp 1/0123/5a", o_ram_we, o_ram_a, o_ram_d); end
    bus(16'hB456, 0, 0);
    checks++; if (o_ram_rd !== 1 || o_dout !== c_ram_q) begin failures++;
      $display("FAIL ram_read got rd=%b dout=%h exp 1/%h", o_ram_rd, o_dout, c_ram_q); end
  endtask

  task automatic test_held_cs();
    int n;
    @(negedge clk); a = 16'h2000; cale = 1;
    @(negedge clk); cale = 0; cs = 1; wr = 1; din = 8'h05;
    @(negedge clk); din = 8'h09;
    @(negedge clk);
    @(negedge clk); cs = 0; wr = 0;
    model_write(16'h2000, 8'h05);
    bus(16'h4000, 0, 0);
    checks++; if (o_rom_a !== exp_rom_a(16'h4000, 127)) begin failures++;
      $display("FAIL held_bank1 got=%h exp=%h", o_rom_a, exp_rom_a(16'h4000, 127)); end
    n = 0;
    @(negedge clk); a = 16'hA777; cale = 1;
    @(negedge clk); cale = 0; cs = 1; wr = 1; din = 8'h66;
    repeat (3) begin #1 if (ram_we === 1) n++; @(negedge clk); end
    cs = 0; wr = 0;
    checks++; if (n !== 1) begin failures++; $display("FAIL held_ram_we pulses got=%0d exp=1", n); end
  endtask

  task automatic test_overlap();
    @(negedge clk); a = 16'h4567; cale = 1;
    @(negedge clk); a = 16'hA000; cale = 1; cs = 1; wr = 0; rom_q = 8'($urandom);
    #1;
    checks++; if (rom_rd !== 1 || rom_a !== exp_rom_a(16'h4567, 127)) begin failures++;
      $display("FAIL overlap_old_alat got rd=%b a=%h exp 1/%h", rom_rd, rom_a, exp_rom_a(16'h4567, 127)); end
    @(negedge clk); cale = 0; cs = 0;
    @(negedge clk); cs = 1;
    #1;
    checks++; if (rom_rd !== 0 || ram_rd !== m_en) begin failures++;
      $display("FAIL overlap_new_alat got rom_rd=%b ram_rd=%b exp 0/%b", rom_rd, ram_rd, m_en); end
    @(negedge clk); cs = 0;
  endtask

  task automatic test_reset_mid();
    wr_model(16'h4000, 8'h02);
    wr_model(16'h6000, 8'h01);
    wr_model(16'h0000, 8'h0A);
    @(negedge clk); a = 16'hA010; cale = 1;
    @(negedge clk); cale = 0; cs = 1; wr = 1; din = 8'h77; rst = 1;
    #1;
    checks++; if (ram_we !== 0) begin failures++; $display("FAIL reset_mid_we got=%b exp=0", ram_we); end
    @(negedge clk); rst = 0; cs = 0; wr = 0;
    model_reset();
    bus(16'h4000, 0, 0);
    checks++; if (o_rom_a !== 21'h04000) begin failures++; $display("FAIL reset_mid_banks got=%h exp=04000", o_rom_a); end
    bus(16'hA000, 0, 0);
    checks++; if (o_dout !== 8'hFF || o_ram_rd !== 0) begin failures++;
      $display("FAIL reset_mid_ram_en got dout=%h rd=%b exp ff/0", o_dout, o_ram_rd); end
    wr_model(16'h0000, 8'h0A);
    bus(16'hA001, 1, 8'h11);
    checks++; if (o_ram_we !== 1) begin failures++; $display("FAIL reset_mid_new_access we=%b exp=1", o_ram_we); end
  endtask

  task automatic test_random();
    logic [15:0] ad; logic [7:0] d; logic w; int r;
    logic [7:0] e_dout;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: ad = 16'($urandom_range(0, 16'h3FFF));
        1: ad = 16'($urandom_range(16'h4000, 16'h7FFF));
        2: ad = 16'($urandom_range(16'hA000, 16'hBFFF));
        3: ad = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(16'h8000, 16'h9FFF))
                                             : 16'($urandom_range(16'hC000, 16'hFFFF));
        default: ad = 16'($urandom_range(0, 16'h1FFF));
      endcase
      w = 1'($urandom);
      d = ($urandom_range(0, 2) == 0) ? {4'($urandom), 4'hA} : 8'($urandom);
      bus(ad, w, d);
      r = region(ad);
      e_dout = (r < 2) ? c_rom_q : (r == 2 && m_en) ? c_ram_q : 8'hFF;
      checks++; if (o_dout !== e_dout) begin failures++;
        $display("FAIL rnd_dout addr=%h wr=%b got=%h exp=%h", ad, w, o_dout, e_dout); end
      checks++; if (o_rom_rd !== (!w && r < 2) || o_ram_rd !== (!w && r == 2 && m_en)) begin failures++;
        $display("FAIL rnd_rd addr=%h got rom_rd=%b ram_rd=%b", ad, o_rom_rd, o_ram_rd); end
      checks++; if (o_ram_we !== (w && r == 2 && m_en)) begin failures++;
        $display("FAIL rnd_we addr=%h wr=%b got=%b", ad, w, o_ram_we); end
      if (r < 2) begin
        checks++; if (o_rom_a !== exp_rom_a(ad, 127) || o_rom_a2 !== exp_rom_a(ad, 31)) begin failures++;
          $display("FAIL rnd_rom_a addr=%h got=%h/%h exp=%h/%h", ad, o_rom_a, o_rom_a2,
                   exp_rom_a(ad, 127), exp_rom_a(ad, 31)); end
      end
      if (r == 2) begin
        checks++; if (o_ram_a !== exp_ram_a(ad) || o_ram_d !== d) begin failures++;
          $display("FAIL rnd_ram_a addr=%h got=%h d=%h exp=%h d=%h", ad, o_ram_a, o_ram_d, exp_ram_a(ad), d); end
      end
      if (w) model_write(ad, d);
    end
  endtask

  initial begin
    test_reset();
    test_bank1();
    test_mode();
    test_ram();
    test_held_cs();
    test_overlap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
